i2c_slave_read_byte: RTL and testbench
======================================

I2C_SLAVE_READ_BYTE -- requirements
Module: i2c_slave_read_byte

Interface
REQ-001 The block SHALL have these ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  one-cycle start request; sampled only in IDLE.
- ack_en  input  1  1 = ACK the received byte, 0 = NACK; sampled when entering ACK_WAIT.
- scl  input  1  raw bus clock.
- sda  input  1  raw bus data.
- data_out  output  8  last received byte, MSB first.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- busy  output  1  high in every state except IDLE.
- finish  output  1  one-cycle pulse when a byte and its ACK/NACK slot complete.
- error  output  1  one-cycle pulse on an abort caused by START or STOP.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 scl and sda SHALL each pass through a 2-bit shift register {prev, cur} that is updated every clock; all decisions SHALL use these registered values only.
- scl_rise = (scl pair == 01); scl_fall = (scl pair == 10).
- start_det = sda pair 10 while scl cur = 1.
- stop_det = sda pair 01 while scl cur = 1.
REQ-004 The FSM SHALL have the states IDLE, READ, ACK_WAIT, ACK_SLOT and DONE, with a 3-bit bit counter bit_cnt.
REQ-005 In IDLE, go = 1 SHALL move to READ with bit_cnt = 0 and clear the shift register. go SHALL be ignored in every other state.
REQ-006 In READ, each scl_rise SHALL shift sda cur into the shift register LSB, so the first bit lands in the MSB after 8 shifts, and SHALL increment bit_cnt.
REQ-007 On the scl_rise that captures the 8th bit (bit_cnt = 7), the FSM SHALL go to ACK_WAIT, and bit_cnt SHALL wrap to 0.
REQ-008 If go and scl_rise occur in the same IDLE cycle, that edge SHALL NOT be sampled; the first bit is the next scl_rise.
REQ-009 In ACK_WAIT, on scl_fall, the FSM SHALL go to ACK_SLOT and set sda_oe = ack_en in the same cycle.
REQ-010 In ACK_SLOT, sda_oe SHALL be held. The slot SHALL end on the first scl_fall that follows an scl_rise; on that fall sda_oe SHALL clear and the FSM SHALL go to DONE.
REQ-011 In DONE, for one cycle, finish SHALL be 1 and data_out SHALL be loaded with the shift register; the FSM SHALL then return to IDLE.
REQ-012 data_out SHALL hold its value until the next DONE or reset.
REQ-013 start_det or stop_det in READ, ACK_WAIT or ACK_SLOT SHALL abort:
- next cycle: error = 1 for one cycle, sda_oe = 0, state = IDLE.
- data_out unchanged; finish not asserted.
REQ-014 If abort and scl_rise occur in the same cycle, the abort SHALL win and no bit SHALL be shifted.
REQ-015 sda_oe SHALL be 0 in IDLE, READ, ACK_WAIT and DONE.
REQ-016 finish and error SHALL never be 1 in the same cycle.
REQ-017 Latency: finish SHALL go high exactly 1 clock after the registered scl_fall that ends the ACK slot.

Reset
REQ-018 While reset = 1, regardless of clock:
- state = IDLE, bit_cnt = 0, shift register = 0x00, data_out = 0x00.
- sda_oe = 0, busy = 0, finish = 0, error = 0.
- both synchronizer pairs = 2'b11 (bus idle).
REQ-019 Reset asserted mid-byte SHALL discard the partial byte and release SDA immediately.
REQ-020 After reset, no stale edge SHALL be detected from the 11 preset.

Verification
REQ-021 go, then 8 SCL pulses carrying 0xA5 with ack_en = 1 -> sda_oe = 1 through the 9th pulse; finish one cycle; data_out = 0xA5.
REQ-022 Byte 0x3C with ack_en = 0 -> sda_oe stays 0 throughout; finish pulses; data_out = 0x3C.
REQ-023 STOP (sda 0->1 with scl high) after 4 bits -> error one cycle; state IDLE; data_out keeps its prior value (0x3C); no finish.
REQ-024 go pulsed again during READ -> ignored; byte 0xFF completes normally; exactly one finish.
REQ-025 reset asserted during ACK_SLOT with sda_oe = 1 -> sda_oe = 0 asynchronously; all outputs at reset values; the next go receives 0x01 correctly.
REQ-026 go coincident with a registered scl_rise -> that edge is ignored; the following 8 rises deliver 0x80 correctly.

Source files
------------

// File: rtl/i2c_slave_read_byte.sv
// I2C slave byte receiver: samples 8 bits MSB first on SCL rises, drives the ACK/NACK slot,
// and aborts on any START or STOP seen mid-transfer.
module i2c_slave_read_byte (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       ack_en,
  input  logic       scl,
  input  logic       sda,
  output logic [7:0] data_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       finish,
  output logic       error
);

  // state    | meaning
  // IDLE     | waiting for go
  // READ     | shifting in 8 data bits on scl rises
  // ACK_WAIT | byte complete, waiting for scl low to take the ACK slot
  // ACK_SLOT | sda_oe driven with ack_en until the 9th clock pulse ends
  // DONE     | one-cycle finish pulse, data_out updated
  typedef enum logic [2:0] {IDLE, READ, ACK_WAIT, ACK_SLOT, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt, data_out_nxt;
  logic       sda_oe_nxt, error_nxt;
  logic       rise_seen, rise_seen_nxt;
  logic       ack_q, ack_q_nxt;
  logic       scl_rise, scl_fall, start_det, stop_det, abort;

  // Pairs preset to 11 so an idle bus produces no edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

  assign scl_rise  = (scl_sync == 2'b01);
  assign scl_fall  = (scl_sync == 2'b10);
  assign start_det = (sda_sync == 2'b10) && scl_sync[0];
  assign stop_det  = (sda_sync == 2'b01) && scl_sync[0];
  assign abort     = start_det || stop_det;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      sda_oe    <= 1'b0;
      error     <= 1'b0;
      rise_seen <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      data_out  <= data_out_nxt;
      sda_oe    <= sda_oe_nxt;
      error     <= error_nxt;
      rise_seen <= rise_seen_nxt;
      ack_q     <= ack_q_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    data_out_nxt  = data_out;
    sda_oe_nxt    = sda_oe;
    error_nxt     = 1'b0;
    rise_seen_nxt = rise_seen;
    ack_q_nxt     = ack_q;
    case (state)
      IDLE: begin
        sda_oe_nxt = 1'b0;
        if (go) begin
          state_nxt   = READ;
          bit_cnt_nxt = 3'd0;
          shreg_nxt   = 8'h00;
        end
      end
      READ: begin
        if (abort) begin
          state_nxt  = IDLE;
          error_nxt  = 1'b1;
          sda_oe_nxt = 1'b0;
        end else if (scl_rise) begin
          shreg_nxt   = {shreg[6:0], sda_sync[0]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = ACK_WAIT;
            ack_q_nxt = ack_en;
          end
        end
      end
      ACK_WAIT: begin
        if (abort) begin
          state_nxt  = IDLE;
          error_nxt  = 1'b1;
          sda_oe_nxt = 1'b0;
        end else if (scl_fall) begin
          state_nxt     = ACK_SLOT;
          sda_oe_nxt    = ack_q;
          rise_seen_nxt = 1'b0;
        end
      end
      ACK_SLOT: begin
        // The slot closes on the fall of the 9th pulse, not the fall that opened it.
        if (abort) begin
          state_nxt  = IDLE;
          error_nxt  = 1'b1;
          sda_oe_nxt = 1'b0;
        end else if (scl_rise) begin
          rise_seen_nxt = 1'b1;
        end else if (scl_fall && rise_seen) begin
          state_nxt    = DONE;
          sda_oe_nxt   = 1'b0;
          data_out_nxt = shreg;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        sda_oe_nxt = 1'b0;
      end
    endcase
  end

  assign busy   = (state != IDLE);
  assign finish = (state == DONE);

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Randomized bench for i2c_slave_read_byte: bytes, ACK/NACK, aborts and resets checked
// against a transaction-level model of the expected byte, pulse counts and SDA drive.
module tb_i2c_slave_read_byte;

  logic       clock = 1'b0;
  logic       reset, go, ack_en, scl, sda;
  logic [7:0] data_out;
  logic       sda_oe, busy, finish, error;

  int         n_cmp = 0, n_err = 0;
  int         fin_cnt = 0, err_cnt = 0, exp_fin = 0, exp_err = 0;
  logic [7:0] exp_data = 8'h00;

  always #5 clock = ~clock;

  i2c_slave_read_byte dut (
    .clock(clock), .reset(reset), .go(go), .ack_en(ack_en), .scl(scl), .sda(sda),
    .data_out(data_out), .sda_oe(sda_oe), .busy(busy), .finish(finish), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    wait_clk(1);
    go = 1'b0;
  endtask

  task automatic bus_bit(input logic b);
    sda = b;
    wait_clk(2);
    scl = 1'b1;
    wait_clk(3);
    scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_bits(input logic [7:0] b, input int go_at);
    for (int i = 7; i >= 0; i--) begin
      bus_bit(b[i]);
      if (7 - i == go_at) pulse_go();
    end
  endtask

  // 9th pulse: SDA drive must match ack, finish must appear exactly one clock after the registered fall.
  task automatic ack_phase(input logic ack, input logic [7:0] b);
    sda = 1'b1;
    chk("oe_slot_entry", sda_oe, ack);
    wait_clk(2);
    scl = 1'b1;
    wait_clk(2);
    chk("oe_high", sda_oe, ack);
    wait_clk(1);
    scl = 1'b0;
    wait_clk(1);
    chk("fin_early", finish, 0);
    chk("oe_hold", sda_oe, ack);
    wait_clk(1);
    chk("fin_pulse", finish, 1);
    chk("oe_release", sda_oe, 0);
    wait_clk(1);
    exp_fin++;
    exp_data = b;
    chk("fin_end", finish, 0);
    chk("data_out", data_out, exp_data);
    chk("busy_done", busy, 0);
    #1;
    chk("fin_cnt", fin_cnt, exp_fin);
    chk("err_cnt", err_cnt, exp_err);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic ack, input int go_at);
    scl = 1'b0;
    ack_en = ack;
    wait_clk(2);
    pulse_go();
    send_bits(b, go_at);
    ack_phase(ack, b);
  endtask

  task automatic abort_byte(input logic [7:0] b, input int nbits, input logic is_stop);
    scl = 1'b0;
    ack_en = 1'b1;
    wait_clk(2);
    pulse_go();
    for (int i = 0; i < nbits; i++) bus_bit(b[7-i]);
    if (is_stop) begin
      sda = 1'b0; wait_clk(2);
      scl = 1'b1; wait_clk(2);
      sda = 1'b1;
    end else begin
      sda = 1'b1; wait_clk(2);
      scl = 1'b1; wait_clk(2);
      sda = 1'b0; wait_clk(2);
      scl = 1'b0; wait_clk(1);
      sda = 1'b1;
    end
    wait_clk(4);
    exp_err++;
    chk("abort_busy", busy, 0);
    chk("abort_oe", sda_oe, 0);
    chk("abort_data", data_out, exp_data);
    #1;
    chk("abort_err_cnt", err_cnt, exp_err);
    chk("abort_fin_cnt", fin_cnt, exp_fin);
  endtask

  always @(negedge clock) begin
    if (finish) fin_cnt++;
    if (error) err_cnt++;
    if (finish || error) chk("fin_err_excl", finish & error, 0);
    if (!busy) chk("oe_when_idle", sda_oe, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       ack;
    reset = 1'b1; go = 1'b0; ack_en = 1'b0; scl = 1'b1; sda = 1'b1;
    wait_clk(3);
    chk("rst_data", data_out, 0);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    wait_clk(3);
    chk("idle_busy", busy, 0);

    rx_byte(8'hA5, 1'b1, -1);
    rx_byte(8'h3C, 1'b0, -1);
    abort_byte(8'hF0, 4, 1'b1);
    rx_byte(8'hFF, 1'b1, 3);

    // Reset in the middle of an ACK slot that is actively pulling SDA.
    scl = 1'b0; ack_en = 1'b1; wait_clk(2);
    pulse_go();
    send_bits(8'h96, -1);
    sda = 1'b1; wait_clk(2);
    scl = 1'b1; wait_clk(2);
    chk("oe_before_rst", sda_oe, 1);
    #2 reset = 1'b1;
    #1;
    exp_data = 8'h00;
    chk("rst_async_oe", sda_oe, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_data", data_out, exp_data);
    chk("rst_async_fin", finish, 0);
    chk("rst_async_err", error, 0);
    wait_clk(2);
    scl = 1'b0;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(2);
    rx_byte(8'h01, 1'b1, -1);

    // go lands in the same cycle as a registered scl rise; that rise must not be sampled.
    scl = 1'b0; sda = 1'b1; ack_en = 1'b1;
    wait_clk(3);
    scl = 1'b1;
    wait_clk(1);
    go = 1'b1;
    wait_clk(1);
    go = 1'b0;
    wait_clk(2);
    scl = 1'b0;
    wait_clk(2);
    send_bits(8'h80, -1);
    ack_phase(1'b1, 8'h80);

    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        abort_byte(b, int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
      else
        rx_byte(b, ack, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1);
    end

    wait_clk(4);
    #1;
    chk("final_fin_cnt", fin_cnt, exp_fin);
    chk("final_err_cnt", err_cnt, exp_err);
    chk("final_data", data_out, exp_data);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
